// File: rtl/key_scan_ctrl.sv
// key_scan_ctrl: front end for a 10-key active-low keypad.
// Synchronises and debounces the raw key lines, priority-encodes them to a
// BCD code (highest index wins) and emits one event per debounced press
// through a one-entry valid/ready output register.
// Optional feature macro: KEY_REPEAT_EN (auto-repeat while a key is held).
module key_scan_ctrl #(
  parameter int DB_CYCLES  = 4,
  parameter int REPEAT_DLY = 16,
  parameter int REPEAT_PER = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] S_n,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [3:0] key_code,
  output logic       out_repeat,
  output logic       key_down,
  output logic       overrun
);

  localparam int MAX_AB = (DB_CYCLES > REPEAT_DLY) ? DB_CYCLES : REPEAT_DLY;
  localparam int MAX_P  = (MAX_AB > REPEAT_PER) ? MAX_AB : REPEAT_PER;
  localparam int CW     = $clog2(MAX_P) + 1;

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

  logic [9:0]    s_meta;
  logic [9:0]    s_sync;
  logic          gs;
  logic [3:0]    code;
  state_t        state;
  logic [3:0]    cand;
  logic [CW-1:0] cnt;
  logic          match;
  logic          db_done;
  logic          ev_press;
  logic          ev_rep;
  logic          ev;

  // Two-flop synchroniser; idles at all-released.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_meta <= 10'h3FF;
      s_sync <= 10'h3FF;
    end else begin
      s_meta <= S_n;
      s_sync <= s_meta;
    end
  end

  // Priority encoder: ascending scan so the highest pressed index wins.
  // NOTE: every always_comb output gets a default first, so no path can
  // leave a value held and infer a latch.
  always_comb begin
    gs   = 1'b0;
    code = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (!s_sync[i]) begin
        gs   = 1'b1;
        code = 4'(i);
      end
    end
  end

`ifdef KEY_REPEAT_EN
  logic [CW-1:0] hold;
  logic          rep_phase;
  logic          rep_q;
  logic [CW-1:0] hold_lim;

  // Hold threshold: initial delay first, then the repeat period.
  always_comb begin
    hold_lim = rep_phase ? CW'(REPEAT_PER - 1) : CW'(REPEAT_DLY - 1);
    ev_rep   = (state == PRESSED) && match && (hold == hold_lim);
  end

  // Hold counter runs only in PRESSED and survives a release glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold      <= '0;
      rep_phase <= 1'b0;
    end else if (ev_press) begin
      hold      <= '0;
      rep_phase <= 1'b0;
    end else if (ev_rep) begin
      hold      <= '0;
      rep_phase <= 1'b1;
    end else if (state == PRESSED && match && hold < hold_lim) begin
      hold <= hold + 1'b1;
    end
  end

  assign out_repeat = rep_q;
`else
  logic rep_q;

  assign ev_rep     = 1'b0;
  assign out_repeat = 1'b0;
`endif

  // Event qualifiers for the current cycle.
  always_comb begin
    match    = gs && (code == cand);
    db_done  = (cnt == CW'(DB_CYCLES - 1));
    ev_press = (state == DEBOUNCE) && match && db_done;
    ev       = ev_press || ev_rep;
  end

  // Debounce FSM plus the one-entry output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cand      <= 4'd0;
      cnt       <= '0;
      key_down  <= 1'b0;
      out_valid <= 1'b0;
      key_code  <= 4'd0;
      rep_q     <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gs) begin
            state <= DEBOUNCE;
            cand  <= code;
            cnt   <= '0;
          end
        end
        DEBOUNCE: begin
          if (!match) begin
            state <= IDLE;
          end else if (db_done) begin
            state    <= PRESSED;
            key_down <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!match) begin
            state <= RELEASE;
            cnt   <= '0;
          end
        end
        RELEASE: begin
          if (match) begin
            state <= PRESSED;
          end else if (db_done) begin
            state    <= IDLE;
            key_down <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      overrun <= 1'b0;
      if (ev) begin
        if (!out_valid || out_ready) begin
          out_valid <= 1'b1;
          key_code  <= cand;
          rep_q     <= ev_rep;
        end else begin
          overrun <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
